// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Multi-channel push-button conditioner. Each raw pin is synchronised by two
// flops and polarity-corrected so that s = 1 means "active". Each channel then
// runs its own four-state debounce FSM. A level change is accepted only after
// DEBOUNCE_CYCLES consecutive stable samples. A separate hold counter produces
// a long-press pulse once the button has been held for LONG_PRESS_CYCLES after
// an accepted press.
//
// Ports
//   i_clk      : single clock; all logic runs on the rising edge
//   i_rst      : asynchronous, active-high reset
//   i_btn      : raw asynchronous button pins (NUM_BTN bits)
//   o_btn      : debounced, polarity-corrected level (1 = pressed)
//   o_press    : one-cycle pulse per accepted press
//   o_release  : one-cycle pulse per accepted release
//   o_long     : one-cycle pulse per long press
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned         NUM_BTN           = 7,
    parameter int unsigned         DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned         LONG_PRESS_CYCLES = 25000000,
    parameter logic [NUM_BTN-1:0]  ACTIVE_LOW_MASK   = 7'b0000001
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_btn,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long
);

    // Zero-length windows would make the FSM accept changes with no filtering
    // and would break the "counter = N-1" compares below.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
        $error("btn_debounce: LONG_PRESS_CYCLES must be >= 1");
    end

    localparam int unsigned MaxCycles =
        (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] LongMax = CntW'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {
        StReleased,
        StWaitPress,
        StPressed,
        StWaitRelease
    } state_e;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. Flops reset to the idle raw level so that an idle
    // button reads inactive straight out of reset and no spurious pulse follows.
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= ACTIVE_LOW_MASK;
            sync2_q <= ACTIVE_LOW_MASK;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    // Polarity correction after synchronisation: s = 1 when the button is active.
    assign s = sync2_q ^ ACTIVE_LOW_MASK;

    // -------------------------------------------------------------------------
    // Per-channel debounce FSM, debounce counter and hold counter.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        state_e          state_q, state_d;
        logic [CntW-1:0] deb_q, deb_d;
        logic [CntW-1:0] hold_q, hold_d;
        logic            btn_q, btn_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            long_q, long_d;
        logic            held_now;
        logic            held_next;

        always_comb begin
            state_d   = state_q;
            deb_d     = deb_q;
            hold_d    = hold_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            btn_d     = 1'b0;
            held_now  = 1'b0;
            held_next = 1'b0;

            unique case (state_q)
                StReleased: begin
                    if (s[g]) begin
                        state_d = StWaitPress;
                        deb_d   = '0;
                    end
                end
                StWaitPress: begin
                    if (!s[g]) begin
                        state_d = StReleased;
                    end else if (deb_q == DebLast) begin
                        state_d = StPressed;
                        press_d = 1'b1;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!s[g]) begin
                        state_d = StWaitRelease;
                        deb_d   = '0;
                    end
                end
                StWaitRelease: begin
                    // A return to active here is a bounce: go back without a pulse.
                    if (s[g]) begin
                        state_d = StPressed;
                    end else if (deb_q == DebLast) begin
                        state_d   = StReleased;
                        release_d = 1'b1;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StReleased;
                    deb_d   = '0;
                end
            endcase

            held_now  = (state_q == StPressed) || (state_q == StWaitRelease);
            held_next = (state_d == StPressed) || (state_d == StWaitRelease);

            // Hold counter restarts on each accepted press and saturates, so the
            // long pulse can fire at most once per press.
            if (press_d) begin
                hold_d = '0;
            end else if (held_now && (hold_q != LongMax)) begin
                hold_d = hold_q + 1'b1;
            end

            // Suppress the long pulse if the channel is leaving the held states
            // on the same edge the counter reaches its limit.
            long_d = (hold_d == LongMax) && (hold_q != LongMax) && held_next;
            btn_d  = held_next;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_q   <= StReleased;
                deb_q     <= '0;
                hold_q    <= '0;
                btn_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                deb_q     <= deb_d;
                hold_q    <= hold_d;
                btn_q     <= btn_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        assign o_btn[g]     = btn_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_long[g]    = long_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10 and the default mask (channel 0 active-low).
// Each scenario pushes the expected per-edge output vector
// {o_btn, o_press, o_release, o_long} into a scoreboard queue, then steps the
// clock and pops/compares one entry per edge, sampling 1 time unit after it.
// Edge numbering: inputs change just after an edge; the next edge is edge 1.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int unsigned NB = 7;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] o_btn;
    logic [NB-1:0] o_press;
    logic [NB-1:0] o_release;
    logic [NB-1:0] o_long;

    int checks   = 0;
    int failures = 0;

    logic [4*NB-1:0] sb[$];
    logic [4*NB-1:0] exp_v;
    logic [4*NB-1:0] got_v;

    btn_debounce #(
        .NUM_BTN          (NB),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .ACTIVE_LOW_MASK  (7'b0000001)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_btn    (btn_in),
        .o_btn    (o_btn),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*NB-1:0] mk(input logic [NB-1:0] b, input logic [NB-1:0] p,
                                          input logic [NB-1:0] r, input logic [NB-1:0] l);
        return {b, p, r, l};
    endfunction

    function automatic logic [4*NB-1:0] outs();
        return {o_btn, o_press, o_release, o_long};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with channel 0 idle (high): everything stays 0 during and after.
    task automatic test_reset();
        rst    = 1'b1;
        btn_in = 7'b0000001;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (outs() !== '0) begin
                failures++;
                $display("FAIL reset_hold k=%0d got=%h exp=0", k, outs());
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) sb.push_back('0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL reset_idle edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    // Channel 1 press accepted on edge 7, then release accepted on edge 7.
    // The hold counter hits its limit on the release edge; no long pulse.
    task automatic test_press();
        btn_in = 7'b0000011;
        for (int k = 1; k <= 10; k++)
            sb.push_back(mk((k >= 7) ? 7'b0000010 : 7'b0, (k == 7) ? 7'b0000010 : 7'b0,
                            7'b0, 7'b0));
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL press edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        btn_in = 7'b0000001;
        for (int k = 1; k <= 10; k++)
            sb.push_back(mk((k < 7) ? 7'b0000010 : 7'b0, 7'b0,
                            (k == 7) ? 7'b0000010 : 7'b0, 7'b0));
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL press_release edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    // Glitches shorter than the debounce window never get accepted.
    task automatic test_glitch();
        logic [6:0] pat;
        pat = 7'b1101110;  // applied MSB first: 1,1,0,1,1,1,0
        for (int k = 1; k <= 17; k++) sb.push_back('0);
        for (int k = 1; k <= 17; k++) begin
            btn_in = (k <= 7 && pat[7-k]) ? 7'b0000011 : 7'b0000001;
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL glitch edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        btn_in = 7'b0000001;
    endtask

    // Held 30 cycles: press on edge 7, long 10 edges later, release edge 7 after.
    task automatic test_long();
        btn_in = 7'b0000011;
        for (int k = 1; k <= 30; k++)
            sb.push_back(mk((k >= 7) ? 7'b0000010 : 7'b0, (k == 7) ? 7'b0000010 : 7'b0,
                            7'b0, (k == 17) ? 7'b0000010 : 7'b0));
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL long_hold edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        btn_in = 7'b0000001;
        for (int k = 1; k <= 12; k++)
            sb.push_back(mk((k < 7) ? 7'b0000010 : 7'b0, 7'b0,
                            (k == 7) ? 7'b0000010 : 7'b0, 7'b0));
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL long_release edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    // Channel 0 is active-low: driving it 0 is a press.
    task automatic test_active_low();
        btn_in = 7'b0000000;
        for (int k = 1; k <= 10; k++)
            sb.push_back(mk((k >= 7) ? 7'b0000001 : 7'b0, (k == 7) ? 7'b0000001 : 7'b0,
                            7'b0, 7'b0));
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL active_low edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        btn_in = 7'b0000001;
        for (int k = 1; k <= 10; k++)
            sb.push_back(mk((k < 7) ? 7'b0000001 : 7'b0, 7'b0,
                            (k == 7) ? 7'b0000001 : 7'b0, 7'b0));
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL active_low_release edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    // Reset mid-debounce (ch2) with ch1 already pressed: outputs clear at once,
    // then both held buttons need the full latency again.
    task automatic test_reset_mid();
        btn_in = 7'b0000011;
        for (int k = 1; k <= 10; k++)
            sb.push_back(mk((k >= 7) ? 7'b0000010 : 7'b0, (k == 7) ? 7'b0000010 : 7'b0,
                            7'b0, 7'b0));
        btn_in = 7'b0000011;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL rmid_pre edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        btn_in = 7'b0000111;
        for (int k = 1; k <= 4; k++) sb.push_back(mk(7'b0000010, 7'b0, 7'b0, 7'b0));
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL rmid_wait edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL rmid_async got=%h exp=0", outs());
        end
        tick();
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL rmid_in_reset got=%h exp=0", outs());
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            sb.push_back(mk((k >= 7) ? 7'b0000110 : 7'b0, (k == 7) ? 7'b0000110 : 7'b0,
                            7'b0, 7'b0));
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL rmid_after edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
        btn_in = 7'b0000001;
        for (int k = 1; k <= 10; k++)
            sb.push_back(mk((k < 7) ? 7'b0000110 : 7'b0, 7'b0,
                            (k == 7) ? 7'b0000110 : 7'b0, 7'b0));
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = sb.pop_front();
            got_v = outs();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL rmid_release edge=%0d got=%h exp=%h", k, got_v, exp_v);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 7'b0000001;
        test_reset();
        test_press();
        test_glitch();
        test_long();
        test_active_low();
        test_reset_mid();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
